// File: rtl/branch_resolve.sv
// Branch resolution: decodes the branch in D, carries it through D->E,
// resolves the real direction in E from forwarded operands, and registers
// the E->M result that the predictor trains on. Also keeps branch and
// mispredict performance counters.
module branch_resolve #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             stallM,
  input  logic             flushM,
  input  logic [31:0]      instrD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      immD,
  input  logic             branchD,
  input  logic             branchL_D,
  input  logic             pred_takeD,
  input  logic [31:0]      src_aE,
  input  logic [31:0]      src_bE,
  output logic             mispredE,
  output logic [31:0]      redirect_pcE,
  output logic             nullify_dsE,
  output logic             linkE,
  output logic [31:0]      link_pcE,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [31:0]      pcM,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [3:0] {
    BT_NONE = 4'd0,
    BT_EQ   = 4'd1,
    BT_NE   = 4'd2,
    BT_LEZ  = 4'd3,
    BT_GTZ  = 4'd4,
    BT_LTZ  = 4'd5,
    BT_GEZ  = 4'd6
  } br_type_e;

  typedef struct packed {
    logic        valid;
    br_type_e    btype;
    logic        likely;
    logic        link;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] target;
  } de_t;

  typedef struct packed {
    logic        branch;
    logic        take;
    logic [31:0] pc;
  } em_t;

  logic [5:0]  op;
  logic [4:0]  rt;
  br_type_e    type_d;
  logic        likely_d;
  logic        link_d;
  logic        valid_d;
  logic [31:0] target_d;
  de_t         de_nxt;
  de_t         de;
  em_t         em;
  logic        cond_e;
  logic        take_e;
  logic        fire_e;

  // Fields not used by the decoder (rs, offset) and the predictor's
  // likely flag, which is re-derived here from the opcode itself.
  logic unused_bits;
  assign unused_bits = ^{instrD[25:21], instrD[15:0], branchL_D};

  assign op = instrD[31:26];
  assign rt = instrD[20:16];

  // Decode: the 0001xx/0101xx opcode families share conditions, op[4]
  // selects likely. REGIMM rt encodes GEZ in rt[0], likely in rt[1],
  // link in rt[4]; rt[3:2] must be zero.
  always_comb begin
    type_d   = BT_NONE;
    likely_d = 1'b0;
    link_d   = 1'b0;
    if (!op[5] && op[3:2] == 2'b01) begin
      likely_d = op[4];
      case (op[1:0])
        2'b00:   type_d = BT_EQ;
        2'b01:   type_d = BT_NE;
        2'b10:   type_d = BT_LEZ;
        default: type_d = BT_GTZ;
      endcase
    end else if (op == 6'b000001 && rt[3:2] == 2'b00) begin
      type_d   = rt[0] ? BT_GEZ : BT_LTZ;
      likely_d = rt[1];
      link_d   = rt[4];
    end
  end

  assign valid_d  = branchD & (type_d != BT_NONE);
  assign target_d = pcD + 32'd4 + (immD << 2);

  assign de_nxt = '{valid:  valid_d,
                    btype:  type_d,
                    likely: likely_d,
                    link:   link_d,
                    pred:   pred_takeD,
                    pc:     pcD,
                    target: target_d};

  // D->E pipeline register; flush wins over stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          de <= '0;
    else if (flushE)  de <= '0;
    else if (!stallE) de <= de_nxt;
  end

  // Resolve the branch condition on the forwarded operands (signed).
  always_comb begin
    cond_e = 1'b0;
    case (de.btype)
      BT_EQ:   cond_e = (src_aE == src_bE);
      BT_NE:   cond_e = (src_aE != src_bE);
      BT_LEZ:  cond_e = src_aE[31] | (src_aE == 32'd0);
      BT_GTZ:  cond_e = ~src_aE[31] & (src_aE != 32'd0);
      BT_LTZ:  cond_e = src_aE[31];
      BT_GEZ:  cond_e = ~src_aE[31];
      default: cond_e = 1'b0;
    endcase
  end

  assign take_e       = de.valid & cond_e;
  assign fire_e       = de.valid & ~stallE;
  assign mispredE     = fire_e & (de.pred ^ take_e);
  assign redirect_pcE = take_e ? de.target : de.pc + 32'd8;
  assign nullify_dsE  = fire_e & de.likely & ~take_e;
  assign linkE        = de.valid & de.link;
  assign link_pcE     = de.pc + 32'd8;

  // E->M register; a stalled E sends a bubble so training happens once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         em <= '0;
    else if (flushM) em <= '0;
    else if (!stallM) begin
      if (stallE) em <= '0;
      else        em <= '{branch: de.valid, take: take_e, pc: de.pc};
    end
  end

  assign branchM      = em.branch;
  assign actual_takeM = em.take;
  assign pcM          = em.pc;

  // Performance counters: one count per branch leaving E, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (fire_e) begin
      br_cnt <= br_cnt + CNT_W'(1);
      if (mispredE) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule
